// File: rtl/regfile_writeback_queue.sv
// Purpose: in-order writeback FIFO feeding the register file's single write port, with forwarding lookups.
// Latency: 1 cycle from acceptance to write_en when the queue is empty and wr_hold=0; one write per cycle.
// Backpressure: mem_ready=!full, alu_ready=!full&&!mem_valid (load path wins); wr_hold stalls draining only.
//
// Ports:
//   alu_valid/alu_addr/alu_data/alu_ready  ALU result handshake
//   mem_valid/mem_addr/mem_data/mem_ready  load result handshake (priority over ALU)
//   wr_hold                                register-file write port busy; freezes the head
//   write_en/write_address_0/write_data    register-file write port, always the head entry
//   lookup_addr_N -> fwd_hit_N/fwd_data_N  operand-fetch forwarding, youngest pending match
//   count/empty/full                       occupancy
module regfile_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alu_valid,
  input  logic [ADDR_W-1:0]          alu_addr,
  input  logic [DATA_W-1:0]          alu_data,
  output logic                       alu_ready,
  input  logic                       mem_valid,
  input  logic [ADDR_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]          mem_data,
  output logic                       mem_ready,
  input  logic                       wr_hold,
  output logic                       write_en,
  output logic [ADDR_W-1:0]          write_address_0,
  output logic [DATA_W-1:0]          write_data,
  input  logic [ADDR_W-1:0]          lookup_addr_0,
  input  logic [ADDR_W-1:0]          lookup_addr_1,
  output logic                       fwd_hit_0,
  output logic                       fwd_hit_1,
  output logic [DATA_W-1:0]          fwd_data_0,
  output logic [DATA_W-1:0]          fwd_data_1,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt_q;
  logic [PTR_W-1:0]  fwd_idx;

  logic              enq;
  logic              pop;
  logic [ADDR_W-1:0] enq_addr;
  logic [DATA_W-1:0] enq_data;

  assign count = cnt_q;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);

  // Readiness looks only at registered full: a pop in the same cycle does not
  // free a slot until the following cycle.
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;

  assign enq      = !full && (mem_valid || alu_valid);
  assign enq_addr = mem_valid ? mem_addr : alu_addr;
  assign enq_data = mem_valid ? mem_data : alu_data;

  assign write_en        = !empty && !wr_hold;
  assign pop             = write_en;
  assign write_address_0 = empty ? '0 : addr_q[rd_ptr];
  assign write_data      = empty ? '0 : data_q[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Entry storage needs no reset: every read is qualified by occupancy.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[wr_ptr] <= enq_addr;
      data_q[wr_ptr] <= enq_data;
    end
  end

  // Walk from oldest (head) to youngest; a later match overrides an earlier
  // one, so the youngest pending write to an address wins.
  always_comb begin
    fwd_hit_0  = 1'b0;
    fwd_hit_1  = 1'b0;
    fwd_data_0 = '0;
    fwd_data_1 = '0;
    fwd_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PTR_W'(i);
      if (CNT_W'(i) < cnt_q) begin
        if (addr_q[fwd_idx] == lookup_addr_0) begin
          fwd_hit_0  = 1'b1;
          fwd_data_0 = data_q[fwd_idx];
        end
        if (addr_q[fwd_idx] == lookup_addr_1) begin
          fwd_hit_1  = 1'b1;
          fwd_data_1 = data_q[fwd_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
module tb_regfile_writeback_queue;

  logic        clk;
  logic        rst_n;
  logic        alu_valid, mem_valid, wr_hold;
  logic [4:0]  alu_addr, mem_addr;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready;
  logic        write_en;
  logic [4:0]  write_address_0;
  logic [31:0] write_data;
  logic [4:0]  lookup_addr_0, lookup_addr_1;
  logic        fwd_hit_0, fwd_hit_1;
  logic [31:0] fwd_data_0, fwd_data_1;
  logic [2:0]  count;
  logic        empty, full;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t sb[$];
  int   vectors = 0;
  int   fails   = 0;

  regfile_writeback_queue #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .wr_hold(wr_hold),
    .write_en(write_en), .write_address_0(write_address_0), .write_data(write_data),
    .lookup_addr_0(lookup_addr_0), .lookup_addr_1(lookup_addr_1),
    .fwd_hit_0(fwd_hit_0), .fwd_hit_1(fwd_hit_1),
    .fwd_data_0(fwd_data_0), .fwd_data_1(fwd_data_1),
    .count(count), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] a, input logic [31:0] d);
    alu_valid = v;
    alu_addr  = a;
    alu_data  = d;
  endtask

  task automatic set_mem(input logic v, input logic [4:0] a, input logic [31:0] d);
    mem_valid = v;
    mem_addr  = a;
    mem_data  = d;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    ent_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  // Every register-file write must match the oldest outstanding expected result.
  always @(negedge clk) begin
    if (rst_n && write_en) begin
      vectors++;
      if (sb.size() == 0) begin
        fails++;
        $error("FAIL wr_unexpected observed=%0h:%0h expected=none", write_address_0, write_data);
      end else begin
        ent_t e;
        e = sb.pop_front();
        assert (write_address_0 === e.a && write_data === e.d) else begin
          fails++;
          $error("FAIL wr_order observed=%0h:%0h expected=%0h:%0h",
                 write_address_0, write_data, e.a, e.d);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    wr_hold = 1'b0;
    set_alu(1'b0, 5'd0, 32'd0);
    set_mem(1'b0, 5'd0, 32'd0);
    lookup_addr_0 = 5'd0;
    lookup_addr_1 = 5'd0;

    // Reset state
    #12;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_wen", write_en, 0);
    chk("rst_waddr", write_address_0, 0);
    chk("rst_wdata", write_data, 0);
    chk("rst_hit0", fwd_hit_0, 0);
    chk("rst_fdata0", fwd_data_0, 0);
    chk("rst_alu_rdy", alu_ready, 1);
    chk("rst_mem_rdy", mem_ready, 1);
    rst_n = 1'b1;
    tick();

    // Single ALU write, 1-cycle latency
    set_alu(1'b1, 5'd4, 32'd10);
    settle();
    chk("t1_alu_rdy", alu_ready, 1);
    push(5'd4, 32'd10);
    tick();
    set_alu(1'b0, 5'd0, 32'd0);
    settle();
    chk("t1_wen", write_en, 1);
    chk("t1_waddr", write_address_0, 4);
    chk("t1_wdata", write_data, 10);
    chk("t1_count", count, 1);
    tick();
    chk("t1_empty", empty, 1);
    chk("t1_wen_off", write_en, 0);

    // Load path priority
    set_mem(1'b1, 5'd5, 32'd5);
    set_alu(1'b1, 5'd1, 32'd2);
    settle();
    chk("t2_mem_rdy", mem_ready, 1);
    chk("t2_alu_rdy", alu_ready, 0);
    push(5'd5, 32'd5);
    tick();
    set_mem(1'b0, 5'd0, 32'd0);
    settle();
    chk("t2_alu_rdy2", alu_ready, 1);
    chk("t2_waddr_r5", write_address_0, 5);
    push(5'd1, 32'd2);
    tick();
    set_alu(1'b0, 5'd0, 32'd0);
    settle();
    chk("t2_waddr_r1", write_address_0, 1);
    chk("t2_wdata_r1", write_data, 2);
    tick();
    chk("t2_empty", empty, 1);

    // Fill under hold, 5th offered result waits for a pop-freed slot
    wr_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_alu(1'b1, 5'(20 + i), 32'(100 + i));
      settle();
      chk("t3_fill_rdy", alu_ready, 1);
      push(5'(20 + i), 32'(100 + i));
      tick();
    end
    set_alu(1'b1, 5'd24, 32'd104);
    settle();
    chk("t3_count4", count, 4);
    chk("t3_full", full, 1);
    chk("t3_alu_rdy_full", alu_ready, 0);
    chk("t3_wen_hold", write_en, 0);
    tick();
    chk("t3_count_held", count, 4);
    wr_hold = 1'b0;
    settle();
    chk("t3_wen_release", write_en, 1);
    chk("t3_no_passthru", alu_ready, 0);
    tick();
    chk("t3_count3", count, 3);
    chk("t3_alu_rdy_freed", alu_ready, 1);
    push(5'd24, 32'd104);
    tick();
    set_alu(1'b0, 5'd0, 32'd0);
    settle();
    chk("t3_count_enq_pop", count, 3);
    chk("t3_wen_consec", write_en, 1);
    tick();
    chk("t3_count2", count, 2);
    tick();
    chk("t3_count1", count, 1);
    tick();
    chk("t3_drained", empty, 1);

    // Forwarding: youngest match, no same-cycle incoming
    wr_hold = 1'b1;
    lookup_addr_0 = 5'd16;
    lookup_addr_1 = 5'd8;
    set_alu(1'b1, 5'd16, 32'd17);
    push(5'd16, 32'd17);
    tick();
    set_alu(1'b1, 5'd16, 32'd99);
    settle();
    chk("t4_hit_old", fwd_hit_0, 1);
    chk("t4_data_old", fwd_data_0, 17);
    push(5'd16, 32'd99);
    tick();
    set_alu(1'b0, 5'd0, 32'd0);
    settle();
    chk("t4_hit0", fwd_hit_0, 1);
    chk("t4_youngest", fwd_data_0, 99);
    chk("t4_hit1", fwd_hit_1, 0);
    chk("t4_data1", fwd_data_1, 0);
    wr_hold = 1'b0;
    settle();
    chk("t4_wen", write_en, 1);
    chk("t4_head_pending", fwd_data_0, 99);
    tick();
    chk("t4_after_pop", fwd_data_0, 99);
    tick();
    chk("t4_hit_gone", fwd_hit_0, 0);
    chk("t4_data_gone", fwd_data_0, 0);

    // Streaming with simultaneous enqueue/pop, pointers wrap
    for (int i = 0; i < 10; i++) begin
      set_alu(1'b1, 5'(8 + i), 32'(1000 + i));
      push(5'(8 + i), 32'(1000 + i));
      tick();
      chk("t5_count1", count, 1);
    end
    set_alu(1'b0, 5'd0, 32'd0);
    tick();
    chk("t5_empty", empty, 1);

    // Asynchronous reset with entries pending
    wr_hold = 1'b1;
    lookup_addr_0 = 5'd3;
    for (int i = 0; i < 3; i++) begin
      set_alu(1'b1, 5'(2 + i), 32'(500 + i));
      tick();
    end
    set_alu(1'b0, 5'd0, 32'd0);
    settle();
    chk("t6_count3", count, 3);
    chk("t6_fwd_pre", fwd_data_0, 501);
    rst_n = 1'b0;
    settle();
    wr_hold = 1'b0;
    settle();
    chk("t6_count0", count, 0);
    chk("t6_wen0", write_en, 0);
    chk("t6_empty", empty, 1);
    chk("t6_hit0", fwd_hit_0, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_stale", write_en, 0);
    end

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_queue.md
# regfile_writeback_queue

Writer-side companion to the processor's two-read/one-write register file. It accepts register results from the ALU and load (memory) datapaths, buffers them in a small in-order FIFO, and drives the register file's single write port (write_en, write_address_0, write_data) one entry per cycle. It also provides forwarding lookups so the operand-fetch stage sees values that are still queued and not yet written.

## Interface

Parameters:

- DEPTH, 4, queue entries; power of two, 2..16
- ADDR_W, 5, register address width
- DATA_W, 32, register data width

Ports:

- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  reset, asynchronous and active-low
- alu_valid  in  1  ALU result offered
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU result accepted this cycle when alu_valid is also high
- mem_valid  in  1  load result offered
- mem_addr  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- mem_ready  out  1  load result accepted this cycle when mem_valid is also high
- wr_hold  in  1  register-file write port unavailable; stalls draining
- write_en  out  1  register-file write strobe
- write_address_0  out  ADDR_W  register-file write address
- write_data  out  DATA_W  register-file write data
- lookup_addr_0, lookup_addr_1  in  ADDR_W  operand-fetch read addresses
- fwd_hit_0, fwd_hit_1  out  1  a pending entry matches the corresponding lookup address
- fwd_data_0, fwd_data_1  out  DATA_W  data of the youngest matching pending entry; 0 when there is no hit
- count  out  $clog2(DEPTH)+1  number of occupied entries
- empty, full  out  1  count==0 and count==DEPTH respectively

## Operation

- FIFO with write pointer, read pointer and count, all registered. Each entry holds {addr, data}.
- Acceptance:
  - mem_ready = !full.
  - alu_ready = !full && !mem_valid. The load path has fixed priority.
  - At most one enqueue per cycle.
- Drain:
  - write_en = !empty && !wr_hold, combinational from state.
  - write_address_0 and write_data always present the head entry. They are 0 when empty.
  - The head is popped at the clock edge ending any cycle in which write_en=1.
- Simultaneous enqueue and pop: count is unchanged and both pointers advance.
- Full: no enqueue, even if a pop occurs in the same cycle. Ready is based on registered full only, with no pass-through.
- Pointers wrap modulo DEPTH.
- Forwarding:
  - Combinational compare of each lookup address against all valid entries.
  - The youngest (most recently enqueued) match wins.
  - The head entry counts as pending, including in the cycle it is being written.
- All 2^ADDR_W addresses are writable, including register 0. There is no special case.
- Data is never modified. Writes reach the register file in exact acceptance order.

## Timing

- Reset (rst_n low, asynchronous): pointers=0, count=0, empty=1, full=0, write_en=0, write_address_0=0, write_data=0, fwd_hit_*=0, fwd_data_*=0, alu_ready=mem_ready=1 (subject to the mem_valid rule).
- Reset asserted mid-operation discards every pending entry immediately. No write_en pulse follows.
- Latency: a result accepted at edge k drives write_en in the cycle after edge k, provided the queue was empty and wr_hold=0. That is a 1-cycle enqueue-to-write latency.
- Throughput: one write per cycle while wr_hold=0.
- wr_hold=1 freezes the head and read pointer; enqueue continues until full.
- Forwarding reflects state after the most recent edge. It does not include a same-cycle incoming result.

## Test plan

- Reset then single ALU write:
  - Stimulus: alu_valid=1, addr=4, data=10 for one cycle.
  - Response: next cycle write_en=1, write_address_0=4, write_data=10, count=1. The following cycle empty=1 and write_en=0.
- Priority:
  - Stimulus: mem (addr=5, data=5) and alu (addr=1, data=2) both valid for one cycle.
  - Response: mem_ready=1, alu_ready=0. Held ALU data enqueues next cycle. Writes occur in order r5 then r1.
- Fill under hold:
  - Stimulus: wr_hold=1 while 5 ALU results are offered.
  - Response: count reaches 4, full=1, alu_ready=0, no write_en.
  - Then release hold: exactly 4 writes in acceptance order on consecutive cycles. The 5th result enters on the first pop-freed cycle, not the same cycle.
- Forwarding youngest:
  - Stimulus: under hold, enqueue r16=17 then r16=99, with lookup_addr_0=16.
  - Response: fwd_hit_0=1, fwd_data_0=99. lookup_addr_1=8 gives fwd_hit_1=0, fwd_data_1=0.
- Simultaneous enqueue/pop and wrap:
  - Stimulus: stream 10 results, one per cycle, with wr_hold=0.
  - Response: count stays 1 throughout, pointers wrap, all 10 writes are correct and in order.
- Reset mid-operation:
  - Stimulus: with 3 entries pending, pulse rst_n low asynchronously (between edges).
  - Response: count=0 and write_en=0 immediately. No stale writes after release.
